// File: rtl/fetch_unit.sv
// Instruction fetch sequencer between the 64x8 RAM and decode/execute: fetches,
// length-decodes and presents bundles, arbitrates stores. FETCH_PERF_EN adds perf counters.
module fetch_unit #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_opcode,
    input  logic [DATA_W-1:0] mem_op1,
    input  logic [DATA_W-1:0] mem_op2,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [DATA_W-1:0] instr_op1,
    output logic [DATA_W-1:0] instr_op2,
    output logic [1:0]        instr_len,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ack,
    output logic              halted,
    output logic              fault
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_instr,
    output logic [15:0]       perf_stall
`endif
);

    typedef enum logic [2:0] {
        ST_ISSUE,
        ST_WAIT,
        ST_PRESENT,
        ST_STORE,
        ST_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W:0]   MEM_TOP = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_opcode;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic [1:0]          r_len;
    logic [ADDR_W-1:0]   r_ipc;
    logic                r_halted;
    logic                r_fault;

    logic [1:0]          w_len;
    logic [ADDR_W:0]     w_end;
    logic                w_overflow;
    logic                w_is_halt;
    logic                w_latch;
    logic                w_accept;
    logic                w_fault_set;
    logic                w_jump;

    always_comb begin
        unique case (mem_opcode[DATA_W-1 -: 2])
            2'b01:   w_len = 2'd2;
            2'b10:   w_len = 2'd3;
            default: w_len = 2'd1;
        endcase
    end

    assign w_end      = {1'b0, r_pc} + (ADDR_W+1)'(w_len);
    assign w_overflow = (w_end > MEM_TOP);
    assign w_is_halt  = (r_opcode[DATA_W-1 -: 2] == 2'b11);
    assign w_jump     = jump_en && (r_state != ST_HALT);

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_accept    = 1'b0;
        w_fault_set = 1'b0;
        unique case (r_state)
            ST_ISSUE:   w_state_nxt = st_req ? ST_STORE : ST_WAIT;
            ST_WAIT: begin
                w_latch     = 1'b1;
                w_fault_set = w_overflow;
                w_state_nxt = w_overflow ? ST_HALT : ST_PRESENT;
            end
            ST_PRESENT: begin
                if (instr_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_is_halt ? ST_HALT : ST_ISSUE;
                end
            end
            ST_STORE:   w_state_nxt = ST_ISSUE;
            default:    w_state_nxt = ST_HALT;
        endcase
        // A redirect discards the in-flight fetch and any same-cycle accept.
        if (w_jump) begin
            w_state_nxt = ST_ISSUE;
            w_latch     = 1'b0;
            w_accept    = 1'b0;
            w_fault_set = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_ISSUE;
            r_pc     <= PC_RST;
            r_opcode <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_len    <= '0;
            r_ipc    <= '0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_jump) begin
                r_pc <= jump_addr;
            end else if (w_accept && !w_is_halt) begin
                r_pc <= r_pc + ADDR_W'(r_len);
            end
            if (w_latch) begin
                r_opcode <= mem_opcode;
                r_op1    <= (w_len >= 2'd2) ? mem_op1 : '0;
                r_op2    <= (w_len == 2'd3) ? mem_op2 : '0;
                r_len    <= w_len;
                r_ipc    <= r_pc;
            end
            if (w_fault_set || (w_accept && w_is_halt)) begin
                r_halted <= 1'b1;
            end
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign mem_addr     = (r_state == ST_STORE) ? st_addr : r_pc;
    assign mem_data     = (r_state == ST_STORE) ? st_data : '0;
    assign mem_we       = (r_state == ST_STORE);
    assign st_ack       = (r_state == ST_STORE);
    assign instr_valid  = (r_state == ST_PRESENT);
    assign instr_opcode = r_opcode;
    assign instr_op1    = r_op1;
    assign instr_op2    = r_op2;
    assign instr_len    = r_len;
    assign instr_pc     = r_ipc;
    assign halted       = r_halted;
    assign fault        = r_fault;

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_instr;
    logic [15:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_instr <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept && (r_perf_instr != '1)) begin
                r_perf_instr <= r_perf_instr + 16'd1;
            end
            if ((r_state == ST_PRESENT) && !instr_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign perf_instr = r_perf_instr;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Memory-side initiator for the 64x8 program/data RAM. It drives the RAM's address, write-data and write-enable inputs, and consumes the RAM's registered opcode/operand1/operand2 read outputs.
- It sequences instruction fetch from a program counter and determines instruction length from the opcode.
- It presents decoded-length instructions to the decoder over a valid/ready handshake, and arbitrates single-byte stores from the execute stage.
- It sits between the RAM and the decode/execute stages of the processor.

Parameters:
- ADDR_W, 6, RAM address width; RAM depth is 2**ADDR_W.
- DATA_W, 8, byte width of data, opcode and operands.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_addr  output  ADDR_W  RAM address.
- mem_data  output  DATA_W  RAM write data.
- mem_we  output  1  RAM write enable.
- mem_opcode  input  DATA_W  RAM byte at captured address.
- mem_op1  input  DATA_W  RAM byte at captured address+1.
- mem_op2  input  DATA_W  RAM byte at captured address+2.
- instr_valid  output  1  instruction bundle valid.
- instr_ready  input  1  decoder accepts bundle.
- instr_opcode, instr_op1, instr_op2  output  DATA_W each  instruction bytes.
- instr_len  output  2  instruction length in bytes, 1..3.
- instr_pc  output  ADDR_W  address of instruction.
- jump_en  input  1  redirect request, one-cycle pulse.
- jump_addr  input  ADDR_W  redirect target.
- st_req  input  1  store request, level, held until st_ack.
- st_addr  input  ADDR_W  store address.
- st_data  input  DATA_W  store data.
- st_ack  output  1  store performed this cycle.
- halted  output  1  fetch stopped (HALT opcode or fault).
- fault  output  1  instruction crossed top of memory.

Behaviour:
- Reset (async, rst_n=0): state=ISSUE, pc=RESET_PC, instr_valid=0, instr_* registers=0, st_ack=0, halted=0, fault=0. mem_we=0 immediately, since it decodes from state.
- Length decode from opcode[7:6]:
  - 00 -> 1 byte.
  - 01 -> 2 bytes.
  - 10 -> 3 bytes.
  - 11 -> HALT, 1 byte.
- RAM contract: RAM samples mem_addr/mem_we on an edge; read data is valid during the following cycle.
- mem_addr, mem_data and mem_we are combinational from state and registers:
  - STORE: mem_addr=st_addr, mem_data=st_data, mem_we=1.
  - Otherwise: mem_addr=pc, mem_data=0, mem_we=0.
- FSM states: ISSUE, WAIT, PRESENT, STORE, HALT.
  - ISSUE: if st_req, go to STORE. Else go to WAIT; the RAM captures pc at this edge.
  - WAIT: latch mem_opcode/op1/op2, len and pc into the instr_* registers.
    - If pc+len > 2**ADDR_W: set fault=1, halted=1, go to HALT.
    - Otherwise go to PRESENT.
    - Unused operand bytes are latched as 0.
  - PRESENT: instr_valid=1; bundle held stable until instr_ready.
    - On valid&&ready with opcode HALT: go to HALT, halted=1.
    - On valid&&ready otherwise: pc += len (mod 2**ADDR_W), go to ISSUE.
  - STORE: exactly one cycle with mem_we=1 and st_ack=1, then go to ISSUE.
  - HALT: absorbing; only reset exits.
- Minimum fetch latency: 2 cycles (ISSUE -> WAIT -> PRESENT). Max throughput: one instruction per 3 cycles.
- jump_en takes priority over everything in every state except HALT:
  - Next state ISSUE, pc=jump_addr, instr_valid=0.
  - Any in-flight fetch is discarded.
  - An accept in the same cycle as jump_en is ignored: jump wins, and the bundle is not counted as accepted.
- Stores are granted only from ISSUE. A store requested in another state waits, with st_req held.
- Store and jump in the same cycle: the jump is taken; the store is granted on a later ISSUE.
- Store to the address currently being fetched: the fetch re-issues after STORE, so new data is returned.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds outputs perf_instr (16-bit) and perf_stall (16-bit):
  - perf_instr increments on each accepted bundle.
  - perf_stall increments on each PRESENT cycle with instr_ready=0.
  - Both saturate at 0xFFFF and reset to 0.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, RAM[0..2]=0x41,0x12,0x34, instr_ready=1 -> instr_valid rises 2 cycles after the first ISSUE with opcode=0x41, op1=0x12, op2=0x00, len=2, pc=0; next instr_pc=2.
- Sequence of 1-, 2- and 3-byte opcodes with instr_ready low for 3 cycles -> bundle held stable; pc advances 0 -> 1 -> 3 -> 6.
- st_req with addr=5, data=0xAA during PRESENT -> store waits until ISSUE; mem_we=1 for exactly one cycle with mem_addr=5, st_ack=1 in that cycle; later fetch at 5 returns 0xAA.
- jump_en with addr=20 in WAIT and again in PRESENT with instr_ready=1 -> current fetch discarded; next bundle has pc=20.
- 3-byte opcode at address 62 -> fault=1, halted=1, instr_valid stays 0. Opcode 0xC0 accepted -> halted=1, mem_we stays 0. Assert rst_n mid-STORE -> mem_we drops immediately.
